fifo_1r1w_rolly: RTL and testbench
==================================

# fifo_1r1w_rolly

Transactional one-read/one-write FIFO with rollback on both sides. Writes stay invisible to the reader until they are committed, and can be dropped instead. Reads stay reserved until they are acknowledged, and can be rolled back for replay. It sits between a speculative producer and a consumer that may need to replay; storage is a synchronous-read 1R1W memory, the hardened-macro-friendly form.

## Interface
- width_p, 32, data width in bits
- lg_size_p, 2, log2 of entry count; depth = 2^lg_size_p
- clk_i  in  1  sole clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- incr_v_i  in  1  acknowledge one read entry (rcptr += 1)
- rollback_v_i  in  1  rewind read pointer to read-commit pointer
- ack_v_i  in  1  acknowledge all dequeued entries (rcptr = rptr)
- clr_v_i  in  1  empty the FIFO (all pointers to 0)
- commit_not_drop_v_i  in  1  write commit/drop strobe
- commit_not_drop_i  in  1  1 = commit pending writes, 0 = drop them
- data_i  in  width_p  write data
- v_i  in  1  write valid
- ready_o  out  1  space available
- data_o  out  width_p  head data, meaningful only when v_o=1
- v_o  out  1  committed, unread entry available
- yumi_i  in  1  consumer takes head; legal only when v_o=1

## Operation
- Four pointers, each lg_size_p+1 bits (MSB is the wrap bit): wptr, wcptr (write commit), rptr, rcptr (read commit).
- Per-cycle events:
  - enq = v_i & ready_o: writes data_i to mem[wptr] and increments wptr.
  - deq = yumi_i: increments rptr.
- ready_o = ~(wptr[lg] != rcptr[lg] & wptr[low] == rcptr[low]). Space is freed only by read acknowledgement.
- v_o = (rptr != wcptr). Only committed data is readable.
- Write side, in priority order:
  - clr_v_i: wptr = wcptr = rptr = rcptr = 0. Same-cycle enq, deq and all other commands are discarded.
  - commit (commit_not_drop_v_i & commit_not_drop_i): wcptr = wptr + enq. The same-cycle write is included in the commit.
  - drop (commit_not_drop_v_i & ~commit_not_drop_i): wptr = wcptr. The same-cycle write is discarded.
- Read side, in priority order:
  - ack_v_i: rcptr = rptr + deq; rptr = rptr + deq. A simultaneous rollback_v_i or incr_v_i is a no-op.
  - rollback_v_i: rptr = rcptr. A same-cycle deq is discarded. A simultaneous incr_v_i gives rcptr += 1 and rptr = rcptr + 1.
  - incr_v_i: rcptr += 1; rptr += deq. The caller guarantees rcptr < rptr + deq.
- Pointer arithmetic is modulo 2^(lg_size_p+1). Wrap-around is natural overflow.
- Memory read address is the next-cycle rptr, so data_o is registered and valid whenever v_o=1.
- Memory is write-first: a read of an address written in the same cycle returns the new data.
- Reset: all pointers 0, ready_o=1, v_o=0, data_o=0.

## Timing
- All state is registered; every command takes effect at the next rising edge.
- Enqueue-to-visible: a write committed in cycle N gives v_o=1 with correct data_o in cycle N+1.
- Space reclaim: ack/incr in cycle N raises ready_o in cycle N+1.
- Dequeue: yumi_i in cycle N presents the next entry on data_o in cycle N+1, giving full throughput of 1 entry/cycle.
- No combinational path from any input to ready_o, v_o or data_o.
- reset_i mid-operation overrides everything; all in-flight and pending data is lost.

## Configuration
- FIFO_ROLLY_ASSERT_EN defined: simulation-only assertions are compiled in. They flag:
  - yumi_i without v_o
  - v_i & ~ready_o held with changing data
  - incr_v_i when rcptr == rptr + deq
  - ack_v_i together with rollback_v_i
- Not defined: no assertions; the RTL is otherwise identical.

## Structure
- Package fifo_rolly_pkg:
  - enum of write-side ops (none, commit, drop, clr)
  - enum of read-side ops (none, incr, ack, rollback)
  - a function that decodes the strobes with the priorities above
- Sub-module fifo_rolly_tracker: holds the four pointers (instance name ft, registers rptr_r, wptr_r, rcptr_r, wcptr_r). It outputs the ready/valid terms and the memory read/write addresses.
- The top module instantiates the tracker plus a synchronous 1R1W write-first memory.

## Test plan
- Reset, enqueue 0xA0..0xA3 with no commit: ready_o falls after the 4th write and v_o stays 0. Then commit: v_o=1 next cycle with data_o=0xA0.
- Enqueue 0xB0, 0xB1, then drop: v_o stays 0 and ready_o stays 1. Next enqueue 0xC0 + commit gives data_o=0xC0.
- Commit 0x10, 0x11, 0x12; dequeue two, then rollback: data_o=0x10 again and v_o=1.
- Same data; dequeue 0x10, incr_v_i, dequeue 0x11, rollback: data_o=0x11.
- Fill 4 committed entries, dequeue all 4: ready_o stays 0 and v_o=0. Assert ack_v_i: ready_o=1 next cycle.
- With 3 committed entries and 1 uncommitted, assert clr_v_i with yumi_i: next cycle v_o=0 and ready_o=1. A fresh write+commit of 0x55 appears as data_o=0x55.

Source files
------------

// File: rtl/fifo_rolly_pkg.sv
// fifo_rolly_pkg: shared op encodings and strobe decoder for the rollback FIFO
package fifo_rolly_pkg;

    typedef enum logic [1:0] {
        wr_none,
        wr_commit,
        wr_drop,
        wr_clr
    } wr_op_e;

    typedef enum logic [1:0] {
        rd_none,
        rd_incr,
        rd_ack,
        rd_rollback
    } rd_op_e;

    typedef struct packed {
        wr_op_e wr;
        rd_op_e rd;
    } ops_t;

    function automatic ops_t decode_ops(
        input logic clr_v,
        input logic cnd_v,
        input logic cnd,
        input logic ack_v,
        input logic rollback_v,
        input logic incr_v
    );
        ops_t o;
        o.wr = clr_v ? wr_clr : cnd_v ? (cnd ? wr_commit : wr_drop) : wr_none;
        o.rd = ack_v ? rd_ack : rollback_v ? rd_rollback : incr_v ? rd_incr : rd_none;
        return o;
    endfunction

endpackage

// File: rtl/fifo_1r1w_rolly_if.sv
// fifo_1r1w_rolly_if: producer/consumer handshake and transaction strobes
interface fifo_1r1w_rolly_if #(
    parameter int width_p = 32
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               commit_not_drop_v_i;
    logic               commit_not_drop_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic               incr_v_i;
    logic               rollback_v_i;
    logic               ack_v_i;
    logic               clr_v_i;

    modport master (
        output v_i, data_i, commit_not_drop_v_i, commit_not_drop_i,
        output yumi_i, incr_v_i, rollback_v_i, ack_v_i, clr_v_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, data_i, commit_not_drop_v_i, commit_not_drop_i,
        input  yumi_i, incr_v_i, rollback_v_i, ack_v_i, clr_v_i,
        output ready_o, v_o, data_o
    );
endinterface

// File: rtl/fifo_rolly_tracker.sv
// fifo_rolly_tracker: write/commit and read/acknowledge pointers (FIFO_ROLLY_ASSERT_EN adds checks)
module fifo_rolly_tracker
    import fifo_rolly_pkg::*;
#(
    parameter int lg_size_p = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  ops_t                 ops,
    input  logic                 incr_v_i,
    input  logic                 v_i,
    input  logic                 yumi_i,
    output logic                 ready,
    output logic                 v,
    output logic                 we,
    output logic [lg_size_p-1:0] waddr,
    output logic [lg_size_p-1:0] raddr
);
    typedef logic [lg_size_p:0] ptr_t;

    ptr_t wptr_r, wcptr_r, rptr_r, rcptr_r;
    ptr_t wptr_n, wcptr_n, rptr_n, rcptr_n;
    ptr_t wptr_inc, rptr_inc, rb_ptr;
    logic clr;

    assign clr = ops.wr == wr_clr;
    // Full only when the writer has lapped the oldest unacknowledged read entry
    assign ready = ~(wptr_r[lg_size_p] != rcptr_r[lg_size_p]
                     && wptr_r[lg_size_p-1:0] == rcptr_r[lg_size_p-1:0]);
    assign v = rptr_r != wcptr_r;
    assign we = v_i & ready & ~clr;
    assign waddr = wptr_r[lg_size_p-1:0];
    assign raddr = rptr_n[lg_size_p-1:0];
    assign wptr_inc = wptr_r + ptr_t'(v_i & ready);
    assign rptr_inc = rptr_r + ptr_t'(yumi_i);
    assign rb_ptr = rcptr_r + ptr_t'(incr_v_i);

    // Next pointer values: clear beats everything, then each side by its own priority
    always_comb begin
        wptr_n = clr ? '0 : ops.wr == wr_drop ? wcptr_r : wptr_inc;
        wcptr_n = clr ? '0 : ops.wr == wr_commit ? wptr_inc : wcptr_r;
        rptr_n = clr ? '0 : ops.rd == rd_rollback ? rb_ptr : rptr_inc;
        rcptr_n = clr ? '0 : ops.rd == rd_ack ? rptr_inc : ops.rd == rd_rollback ? rb_ptr
                : ops.rd == rd_incr ? rcptr_r + ptr_t'(1) : rcptr_r;
    end

    // Pointer registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            wcptr_r <= '0;
            rptr_r <= '0;
            rcptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            wcptr_r <= wcptr_n;
            rptr_r <= rptr_n;
            rcptr_r <= rcptr_n;
        end
    end

`ifdef FIFO_ROLLY_ASSERT_EN
    // Acknowledging past the read pointer would release unread entries
    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (!(incr_v_i && !clr && ops.rd != rd_ack && rcptr_r == rptr_inc))
                else $error("incr_v_i with nothing left to acknowledge");
    end
`endif

endmodule

// File: rtl/fifo_1r1w_rolly.sv
// fifo_1r1w_rolly: transactional 1R1W FIFO with write commit/drop and read ack/rollback (FIFO_ROLLY_ASSERT_EN enables sim checks)
module fifo_1r1w_rolly
    import fifo_rolly_pkg::*;
#(
    parameter int width_p   = 32,
    parameter int lg_size_p = 2
) (
    input logic               clk_i,
    input logic               reset_i,
    fifo_1r1w_rolly_if.slave  bus
);
    ops_t                 ops;
    logic                 ready, v, we;
    logic [lg_size_p-1:0] waddr, raddr;
    logic [width_p-1:0]   mem [0:(1<<lg_size_p)-1];
    logic [width_p-1:0]   data_r;

    assign ops = decode_ops(bus.clr_v_i, bus.commit_not_drop_v_i, bus.commit_not_drop_i,
                            bus.ack_v_i, bus.rollback_v_i, bus.incr_v_i);

    fifo_rolly_tracker #(.lg_size_p(lg_size_p)) ft (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .ops      (ops),
        .incr_v_i (bus.incr_v_i),
        .v_i      (bus.v_i),
        .yumi_i   (bus.yumi_i),
        .ready    (ready),
        .v        (v),
        .we       (we),
        .waddr    (waddr),
        .raddr    (raddr)
    );

    // Storage array, no reset so it maps onto a memory macro
    always_ff @(posedge clk_i) begin
        if (we)
            mem[waddr] <= bus.data_i;
    end

    // Registered read of next cycle's head; same-address write bypasses to keep write-first behaviour
    always_ff @(posedge clk_i) begin
        if (reset_i)
            data_r <= '0;
        else
            data_r <= (we && waddr == raddr) ? bus.data_i : mem[raddr];
    end

    assign bus.ready_o = ready;
    assign bus.v_o = v;
    assign bus.data_o = data_r;

`ifdef FIFO_ROLLY_ASSERT_EN
    logic               hold_q;
    logic [width_p-1:0] held_q;

    // Protocol checks on the producer and consumer
    always_ff @(posedge clk_i) begin
        hold_q <= ~reset_i & bus.v_i & ~ready;
        held_q <= bus.data_i;
        if (!reset_i) begin
            assert (!(bus.yumi_i && !v)) else $error("yumi_i without v_o");
            assert (!(hold_q && bus.v_i && bus.data_i != held_q)) else $error("data_i changed while stalled");
            assert (!(bus.ack_v_i && bus.rollback_v_i)) else $error("ack_v_i together with rollback_v_i");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_1r1w_rolly.sv
// tb_fifo_1r1w_rolly: directed plan plus random traffic checked against a queue model
module tb_fifo_1r1w_rolly;
    logic clk = 1'b0;
    logic reset_i;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] avail[$];
    logic [31:0] rd_pend[$];
    logic [31:0] spec[$];
    logic hold = 1'b0;

    fifo_1r1w_rolly_if #(.width_p(32)) bus ();

    fifo_1r1w_rolly #(.width_p(32), .lg_size_p(2)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic int total();
        return avail.size() + rd_pend.size() + spec.size();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic enq;
        enq = bus.v_i && total() < 4;
        @(posedge clk);
        if (reset_i || bus.clr_v_i) begin
            avail.delete();
            rd_pend.delete();
            spec.delete();
        end else begin
            if (bus.ack_v_i) begin
                if (bus.yumi_i) void'(avail.pop_front());
                rd_pend.delete();
            end else if (bus.rollback_v_i) begin
                for (int i = rd_pend.size() - 1; i >= 0; i--) avail.push_front(rd_pend[i]);
                rd_pend.delete();
                if (bus.incr_v_i) void'(avail.pop_front());
            end else begin
                if (bus.yumi_i) rd_pend.push_back(avail.pop_front());
                if (bus.incr_v_i) void'(rd_pend.pop_front());
            end
            if (bus.commit_not_drop_v_i && bus.commit_not_drop_i) begin
                if (enq) spec.push_back(bus.data_i);
                foreach (spec[i]) avail.push_back(spec[i]);
                spec.delete();
            end else if (bus.commit_not_drop_v_i) begin
                spec.delete();
            end else if (enq) begin
                spec.push_back(bus.data_i);
            end
        end
        #1;
        bus.v_i = 0;
        bus.commit_not_drop_v_i = 0;
        bus.commit_not_drop_i = 0;
        bus.yumi_i = 0;
        bus.incr_v_i = 0;
        bus.rollback_v_i = 0;
        bus.ack_v_i = 0;
        bus.clr_v_i = 0;
        chk("ready", {31'b0, bus.ready_o}, {31'b0, total() < 4});
        chk("v", {31'b0, bus.v_o}, {31'b0, avail.size() != 0});
        if (avail.size() != 0) chk("data", bus.data_o, avail[0]);
    endtask

    task automatic op(input logic v, input logic [31:0] d, input logic commit, input logic drop,
                      input logic yumi, input logic incr, input logic rb, input logic ack, input logic clr);
        bus.v_i = v;
        bus.data_i = d;
        bus.commit_not_drop_v_i = commit | drop;
        bus.commit_not_drop_i = commit;
        bus.yumi_i = yumi;
        bus.incr_v_i = incr;
        bus.rollback_v_i = rb;
        bus.ack_v_i = ack;
        bus.clr_v_i = clr;
        tick();
    endtask

    initial begin
        int r, s;
        logic y;
        bus.v_i = 0;
        bus.data_i = 0;
        bus.commit_not_drop_v_i = 0;
        bus.commit_not_drop_i = 0;
        bus.yumi_i = 0;
        bus.incr_v_i = 0;
        bus.rollback_v_i = 0;
        bus.ack_v_i = 0;
        bus.clr_v_i = 0;
        reset_i = 1;
        tick();
        tick();
        reset_i = 0;
        chk("rst_ready", {31'b0, bus.ready_o}, 32'd1);
        chk("rst_v", {31'b0, bus.v_o}, 32'd0);
        chk("rst_data", bus.data_o, 32'd0);

        for (int i = 0; i < 4; i++) op(1, 32'hA0 + i, 0, 0, 0, 0, 0, 0, 0);
        chk("uncommitted_full_ready", {31'b0, bus.ready_o}, 32'd0);
        chk("uncommitted_v", {31'b0, bus.v_o}, 32'd0);
        op(0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("commit_v", {31'b0, bus.v_o}, 32'd1);
        chk("commit_data", bus.data_o, 32'hA0);
        for (int i = 0; i < 3; i++) op(0, 0, 0, 0, 1, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 0, 1, 0);
        chk("drain_ready", {31'b0, bus.ready_o}, 32'd1);

        op(1, 32'hB0, 0, 0, 0, 0, 0, 0, 0);
        op(1, 32'hB1, 0, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("drop_v", {31'b0, bus.v_o}, 32'd0);
        chk("drop_ready", {31'b0, bus.ready_o}, 32'd1);
        op(1, 32'hC0, 1, 0, 0, 0, 0, 0, 0);
        chk("after_drop_data", bus.data_o, 32'hC0);
        op(0, 0, 0, 0, 1, 0, 0, 1, 0);

        op(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        op(1, 32'h11, 0, 0, 0, 0, 0, 0, 0);
        op(1, 32'h12, 1, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("rollback_v", {31'b0, bus.v_o}, 32'd1);
        chk("rollback_data", bus.data_o, 32'h10);

        op(0, 0, 0, 0, 1, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 1, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("incr_rollback_data", bus.data_o, 32'h11);
        op(0, 0, 0, 0, 1, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 0, 1, 0);

        for (int i = 0; i < 4; i++) op(1, 32'hD0 + i, i == 3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) op(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("unacked_ready", {31'b0, bus.ready_o}, 32'd0);
        chk("unacked_v", {31'b0, bus.v_o}, 32'd0);
        op(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("ack_ready", {31'b0, bus.ready_o}, 32'd1);

        op(1, 32'hE0, 0, 0, 0, 0, 0, 0, 0);
        op(1, 32'hE1, 0, 0, 0, 0, 0, 0, 0);
        op(1, 32'hE2, 1, 0, 0, 0, 0, 0, 0);
        op(1, 32'hE3, 0, 0, 0, 0, 0, 0, 0);
        chk("preclr_ready", {31'b0, bus.ready_o}, 32'd0);
        op(0, 0, 0, 0, 1, 0, 0, 0, 1);
        chk("clr_v", {31'b0, bus.v_o}, 32'd0);
        chk("clr_ready", {31'b0, bus.ready_o}, 32'd1);
        op(1, 32'h55, 1, 0, 0, 0, 0, 0, 0);
        chk("postclr_v", {31'b0, bus.v_o}, 32'd1);
        chk("postclr_data", bus.data_o, 32'h55);
        op(0, 0, 0, 0, 1, 0, 0, 1, 0);

        for (int n = 0; n < 800; n++) begin
            y = avail.size() != 0 && $urandom_range(0, 1) == 1;
            bus.yumi_i = y;
            bus.v_i = $urandom_range(0, 2) != 0;
            if (!hold) bus.data_i = $urandom;
            r = $urandom_range(0, 5);
            bus.commit_not_drop_v_i = r < 3;
            bus.commit_not_drop_i = r != 2;
            s = $urandom_range(0, 9);
            bus.ack_v_i = s == 0;
            bus.rollback_v_i = s == 1 || s == 4;
            bus.incr_v_i = (s >= 2 && s <= 4) && (rd_pend.size() != 0 || y);
            bus.clr_v_i = $urandom_range(0, 40) == 0;
            hold = bus.v_i && total() >= 4;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
